// File: rtl/ibex_rf_pkg.sv
// Shared types and limits for the multi-port flip-flop register file.
package ibex_rf_pkg;

  localparam int unsigned RF_ADDR_WIDTH_I    = 5;
  localparam int unsigned RF_ADDR_WIDTH_E    = 4;
  localparam int unsigned RF_PORT_ADDR_WIDTH = 5;
  localparam int unsigned RF_MAX_READ_PORTS  = 4;
  localparam int unsigned RF_MAX_WRITE_PORTS = 2;

  typedef enum logic [1:0] {
    RF_CLR_IDLE,
    RF_CLR_RUN,
    RF_CLR_DONE
  } rf_clr_state_e;

  function automatic int unsigned rf_addr_width(input bit rv32e);
    return rv32e ? RF_ADDR_WIDTH_E : RF_ADDR_WIDTH_I;
  endfunction

endpackage

// File: rtl/ibex_rf_clear_ctrl.sv
// Bulk-clear sequencer: walks clr_idx from 1 to the last word, one word per
// cycle, then emits a single-cycle done pulse.
module ibex_rf_clear_ctrl
  import ibex_rf_pkg::*;
#(
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_req,
  output logic                 clr_we,
  output logic [AddrWidth-1:0] clr_idx,
  output logic                 busy,
  output logic                 done
);

  localparam logic [AddrWidth-1:0] LAST_IDX = '1;

  rf_clr_state_e state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_CLR_IDLE;
      clr_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        RF_CLR_IDLE: begin
          if (clear_req) begin
            state   <= RF_CLR_RUN;
            clr_idx <= AddrWidth'(1);
            busy    <= 1'b1;
          end
        end
        RF_CLR_RUN: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state <= RF_CLR_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        RF_CLR_DONE: begin
          state <= RF_CLR_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= RF_CLR_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we = busy;

endmodule

// File: rtl/ibex_register_file_mp.sv
// Flip-flop multi-port integer register file with bulk clear and write-collision
// detection. Define RF_WRITE_BYPASS_EN for same-cycle write-to-read forwarding.
module ibex_register_file_mp
  import ibex_rf_pkg::*;
#(
  parameter bit          RV32E         = 1'b0,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumReadPorts  = 2,
  parameter int unsigned NumWritePorts = 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NumReadPorts*RF_PORT_ADDR_WIDTH-1:0]  raddr_i,
  output logic [NumReadPorts*DataWidth-1:0]           rdata_o,
  input  logic [NumWritePorts*RF_PORT_ADDR_WIDTH-1:0] waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0]          wdata_i,
  input  logic [NumWritePorts-1:0]                    we_i,
  output logic                                       wr_ready_o,
  output logic                                       wr_collision_o,
  input  logic                                       clear_req_i,
  output logic                                       clear_busy_o,
  output logic                                       clear_done_o
);

  localparam int unsigned AddrWidth = rf_addr_width(RV32E);
  localparam int unsigned NumWords  = 2 ** AddrWidth;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] word_t;

  addr_t                    raddr [NumReadPorts];
  word_t                    rdata [NumReadPorts];
  addr_t                    waddr [NumWritePorts];
  word_t                    wdata [NumWritePorts];
  logic [NumWritePorts-1:0] we_acc;
  word_t                    mem   [1:NumWords-1];
  logic                     clr_we;
  addr_t                    clr_idx;

  // Upper address bits are don't-care in RV32E mode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr_i, waddr_i};

  ibex_rf_clear_ctrl #(
    .AddrWidth(AddrWidth)
  ) u_clear_ctrl (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .clear_req(clear_req_i),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx),
    .busy     (clear_busy_o),
    .done     (clear_done_o)
  );

  assign wr_ready_o = ~clr_we;

  for (genvar r = 0; r < NumReadPorts; r++) begin : g_rport
    assign raddr[r] = raddr_i[r*RF_PORT_ADDR_WIDTH +: AddrWidth];
    assign rdata_o[r*DataWidth +: DataWidth] = rdata[r];
  end

  for (genvar w = 0; w < NumWritePorts; w++) begin : g_wport
    assign waddr[w]  = waddr_i[w*RF_PORT_ADDR_WIDTH +: AddrWidth];
    assign wdata[w]  = wdata_i[w*DataWidth +: DataWidth];
    assign we_acc[w] = we_i[w] & wr_ready_o & (waddr[w] != '0);
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_collision_o = 1'b0;
    for (int i = 0; i < NumWritePorts; i++) begin
      for (int j = i + 1; j < NumWritePorts; j++) begin
        if (we_i[i] && we_i[j] && (waddr[i] == waddr[j]) && (waddr[i] != '0)) begin
          wr_collision_o = 1'b1;
        end
      end
    end
  end

  // NOTE: the array is reset word by word because reset must zero the
  // architectural state; this keeps it in flip-flops rather than RAM macros.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 1; w < NumWords; w++) begin
        mem[w] <= '0;
      end
    end else begin
      for (int w = 1; w < NumWords; w++) begin
        if (clr_we && (clr_idx == addr_t'(w))) begin
          mem[w] <= '0;
        end
        // Later ports overwrite earlier ones, giving the higher index priority.
        for (int p = 0; p < NumWritePorts; p++) begin
          if (we_acc[p] && (waddr[p] == addr_t'(w))) begin
            mem[w] <= wdata[p];
          end
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NumReadPorts; r++) begin
      rdata[r] = '0;
      for (int w = 1; w < NumWords; w++) begin
        if (raddr[r] == addr_t'(w)) begin
          rdata[r] = mem[w];
        end
      end
`ifdef RF_WRITE_BYPASS_EN
      for (int p = 0; p < NumWritePorts; p++) begin
        if (we_acc[p] && (waddr[p] == raddr[r])) begin
          rdata[r] = wdata[p];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Directed bench for ibex_register_file_mp: a 32-word dual-write instance and a
// 16-word (RV32E) single-write instance.
module tb_ibex_register_file_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #50 clk = ~clk;

  logic [9:0]  raddr_a;
  logic [63:0] rdata_a;
  logic [9:0]  waddr_a;
  logic [63:0] wdata_a;
  logic [1:0]  we_a;
  logic        ready_a, coll_a, req_a, busy_a, done_a;

  logic [9:0]  raddr_b;
  logic [63:0] rdata_b;
  logic [4:0]  waddr_b;
  logic [31:0] wdata_b;
  logic [0:0]  we_b;
  logic        ready_b, coll_b, req_b, busy_b, done_b;

  int n_checks = 0;
  int n_errors = 0;

  ibex_register_file_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr_a), .rdata_o(rdata_a),
    .waddr_i(waddr_a), .wdata_i(wdata_a), .we_i(we_a), .wr_ready_o(ready_a),
    .wr_collision_o(coll_a), .clear_req_i(req_a), .clear_busy_o(busy_a),
    .clear_done_o(done_a)
  );

  ibex_register_file_mp #(
    .RV32E(1'b1), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr_b), .rdata_o(rdata_b),
    .waddr_i(waddr_b), .wdata_i(wdata_b), .we_i(we_b), .wr_ready_o(ready_b),
    .wr_collision_o(coll_b), .clear_req_i(req_b), .clear_busy_o(busy_b),
    .clear_done_o(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd_a(input logic [4:0] a, output logic [31:0] d);
    raddr_a[4:0] = a;
    #1;
    d = rdata_a[31:0];
  endtask

  task automatic rd_b(input logic [4:0] a, output logic [31:0] d);
    raddr_b[4:0] = a;
    #1;
    d = rdata_b[31:0];
  endtask

  task automatic wr_a(input int port, input logic [4:0] a, input logic [31:0] d);
    waddr_a[port*5 +: 5]  = a;
    wdata_a[port*32 +: 32] = d;
    we_a       = '0;
    we_a[port] = 1'b1;
    tick();
    we_a = '0;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] byp_exp;
    int          busy_cnt, done_cnt, nz;

    raddr_a = '0; waddr_a = '0; wdata_a = '0; we_a = '0; req_a = 1'b0;
    raddr_b = '0; waddr_b = '0; wdata_b = '0; we_b = '0; req_b = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state: every address reads zero on both ports.
    for (int a = 0; a < 32; a++) begin
      raddr_a = {5'(31 - a), 5'(a)};
      #1;
      check("rst_rd0", rdata_a[31:0], 32'h0);
      check("rst_rd1", rdata_a[63:32], 32'h0);
    end
    check("rst_ready", 32'(ready_a), 32'h1);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    check("rst_ready_e", 32'(ready_b), 32'h1);
    check("rst_coll_e", 32'(coll_b), 32'h0);
    tick();

    // Basic writes, including the hardwired-zero word.
    wr_a(0, 5'd5, 32'hDEADBEEF);
    rd_a(5'd5, d);
    check("wr_x5", d, 32'hDEADBEEF);
    wr_a(0, 5'd0, 32'h12345678);
    rd_a(5'd0, d);
    check("wr_x0", d, 32'h0);

    // Dual-port collision and non-colliding writes.
    waddr_a = {5'd7, 5'd7}; wdata_a = {32'h2, 32'h1}; we_a = 2'b11;
    #1;
    check("coll_same", 32'(coll_a), 32'h1);
    tick();
    we_a = '0;
    #1;
    check("coll_idle", 32'(coll_a), 32'h0);
    rd_a(5'd7, d);
    check("coll_prio", d, 32'h2);
    waddr_a = {5'd8, 5'd7}; wdata_a = {32'h4, 32'h3}; we_a = 2'b11;
    #1;
    check("coll_diff", 32'(coll_a), 32'h0);
    tick();
    we_a = '0;
    rd_a(5'd7, d);
    check("diff_x7", d, 32'h3);
    rd_a(5'd8, d);
    check("diff_x8", d, 32'h4);
    waddr_a = {5'd0, 5'd0}; we_a = 2'b11;
    #1;
    check("coll_x0", 32'(coll_a), 32'h0);
    tick();
    we_a = '0;

    // Same-cycle read of a word being written.
    wr_a(0, 5'd9, 32'h11111111);
`ifdef RF_WRITE_BYPASS_EN
    byp_exp = 32'hA5A5A5A5;
`else
    byp_exp = 32'h11111111;
`endif
    waddr_a[4:0] = 5'd9; wdata_a[31:0] = 32'hA5A5A5A5; we_a = 2'b01;
    raddr_a[9:5] = 5'd9;
    #1;
    check("byp_same", rdata_a[63:32], byp_exp);
    tick();
    we_a = '0;
    #1;
    check("byp_next", rdata_a[63:32], 32'hA5A5A5A5);

    // Fill x1..x31 with their index, then bulk clear.
    for (int i = 1; i < 32; i++) wr_a(0, 5'(i), 32'(i));
    rd_a(5'd31, d);
    check("fill_x31", d, 32'd31);
    req_a = 1'b1;
    waddr_a[4:0] = 5'd2; wdata_a[31:0] = 32'hBB; we_a = 2'b01;
    tick();
    req_a = 1'b0;
    we_a  = '0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (busy_a) busy_cnt++;
      if (done_a) begin
        done_cnt++;
        check("done_ready", 32'(ready_a), 32'h1);
      end
      if (busy_a && busy_cnt == 1) check("clr_ready", 32'(ready_a), 32'h0);
      if (busy_a && busy_cnt == 2) begin
        rd_a(5'd1, d);  check("mid_x1", d, 32'h0);
        rd_a(5'd2, d);  check("mid_x2", d, 32'hBB);
        rd_a(5'd31, d); check("mid_x31", d, 32'd31);
      end
      req_a = busy_a && (busy_cnt == 5);
      if (busy_a && busy_cnt == 10) begin
        waddr_a = {5'd4, 5'd3}; wdata_a = {32'h44, 32'h33}; we_a = 2'b11;
      end else begin
        we_a = '0;
      end
      if (!busy_a && !done_a && done_cnt > 0) break;
      tick();
    end
    req_a = 1'b0;
    we_a  = '0;
    check("clr_busy_len", 32'(busy_cnt), 32'd31);
    check("clr_done_cnt", 32'(done_cnt), 32'd1);
    nz = 0;
    for (int a = 1; a < 32; a++) begin
      rd_a(5'(a), d);
      if (d != 32'h0) nz++;
    end
    check("clr_nonzero", 32'(nz), 32'h0);
    rd_a(5'd3, d);
    check("clr_x3_drop", d, 32'h0);
    repeat (2) tick();
    #1;
    check("clr_no_rerun", 32'(busy_a), 32'h0);

    // RV32E instance: bit 4 of the address is ignored, clear takes 15 cycles.
    waddr_b = 5'd20; wdata_b = 32'h20; we_b = 1'b1;
    tick();
    we_b = '0;
    rd_b(5'd4, d);
    check("e_x4", d, 32'h20);
    rd_b(5'd20, d);
    check("e_x20", d, 32'h20);
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (busy_b) busy_cnt++;
      if (done_b) done_cnt++;
      if (!busy_b && !done_b && done_cnt > 0) break;
      tick();
    end
    check("e_busy_len", 32'(busy_cnt), 32'd15);
    check("e_done_cnt", 32'(done_cnt), 32'd1);
    rd_b(5'd4, d);
    check("e_x4_clr", d, 32'h0);

    // Reset in the middle of a clear.
    wr_a(0, 5'd30, 32'hCAFE);
    wr_a(0, 5'd5, 32'hDEADBEEF);
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (busy_a) busy_cnt++;
      if (busy_cnt == 10) break;
      tick();
    end
    check("mrst_reach", 32'(busy_cnt), 32'd10);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy_a), 32'h0);
    check("mrst_done", 32'(done_a), 32'h0);
    check("mrst_ready", 32'(ready_a), 32'h1);
    nz = 0;
    for (int a = 1; a < 32; a++) begin
      rd_a(5'(a), d);
      if (d != 32'h0) nz++;
    end
    check("mrst_nonzero", 32'(nz), 32'h0);
    tick();
    rst_n = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      #1;
      if (busy_a) busy_cnt++;
      if (done_a) done_cnt++;
    end
    check("mrst_no_busy", 32'(busy_cnt), 32'h0);
    check("mrst_no_done", 32'(done_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibex_register_file_mp.md
Name: ibex_register_file_mp

Overview:
- Flip-flop-based, multi-port integer register file. Parametrised in data width, read/write port count and RV32E depth.
- Adds a sequential bulk-clear engine that zeroes every architectural register one word per cycle, plus write-collision detection.
- Sits in the ID stage in place of the single-write-port latch register file. Also serves dual-issue and scrub experiments.

Parameters:
- RV32E, 0, 1 selects 16 words (4-bit address), 0 selects 32 words (5-bit address).
- DataWidth, 32, bits per register word.
- NumReadPorts, 2, number of independent combinational read ports (1..4).
- NumWritePorts, 1, number of write ports (1..2). Higher index has priority.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- raddr_i  in  NumReadPorts*5  packed read addresses; port p uses bits [5p+4:5p].
- rdata_o  out  NumReadPorts*DataWidth  packed read data.
- waddr_i  in  NumWritePorts*5  packed write addresses.
- wdata_i  in  NumWritePorts*DataWidth  packed write data.
- we_i  in  NumWritePorts  per-port write enable.
- wr_ready_o  out  1  high when writes are accepted (low while clearing).
- wr_collision_o  out  1  combinational: two enabled write ports target the same nonzero address.
- clear_req_i  in  1  request bulk clear; sampled in IDLE only.
- clear_busy_o  out  1  high while the clear engine runs.
- clear_done_o  out  1  single-cycle pulse when the clear completes.

Behaviour:
- Depth and addressing:
  - ADDR_WIDTH = RV32E ? 4 : 5; NUM_WORDS = 2**ADDR_WIDTH.
  - Address bits above ADDR_WIDTH are ignored on all ports.
- Word 0:
  - Has no storage; reads of address 0 always return 0.
  - Writes to address 0 are dropped and never count as collisions.
- Reset:
  - All words become 0 and the FSM goes to IDLE.
  - Outputs: clear_busy_o=0, clear_done_o=0, wr_ready_o=1.
- Read:
  - Purely combinational, zero latency: rdata port p = mem[raddr p].
- Write:
  - On a rising edge with wr_ready_o=1, each port with we=1 and nonzero address writes mem[waddr] <= wdata.
  - Data is visible on reads the following cycle.
- Collision:
  - When two ports write the same word, the higher-index port's data is stored.
  - wr_collision_o is asserted in that cycle; it is 0 whenever NumWritePorts=1.
- Clear FSM (states IDLE, CLEAR, DONE; counter clr_idx of ADDR_WIDTH bits):
  - IDLE: clear_req_i=1 -> CLEAR with clr_idx=1. Writes in that same cycle are still performed.
  - CLEAR: each cycle mem[clr_idx] <= 0 and clr_idx increments. clear_busy_o=1, wr_ready_o=0, and all we_i are ignored.
  - CLEAR exit: on clr_idx == NUM_WORDS-1 the word is cleared and the FSM goes to DONE. CLEAR lasts NUM_WORDS-1 cycles.
  - DONE: clear_done_o=1 for exactly one cycle, clear_busy_o=0, wr_ready_o=1. Writes are accepted. The FSM returns to IDLE.
  - clear_req_i is ignored in CLEAR and DONE.
- Reads during CLEAR return current contents: 0 for words already cleared, old values for the rest.
- Reset asserted mid-clear: immediate return to IDLE with every word 0. No clear_done_o pulse.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: same-cycle forwarding. If a read address matches an accepted write (we=1, nonzero address, wr_ready_o=1), rdata returns the incoming wdata combinationally. The highest-index matching write port wins.
- Not defined: no forwarding; reads return stored contents only, and new data appears the next cycle.

Decomposition:
- Shared package ibex_rf_pkg holds:
  - the clear-FSM state enum (rf_clr_state_e: RF_CLR_IDLE, RF_CLR_RUN, RF_CLR_DONE);
  - localparams for address width per mode;
  - the read-port and write-port maximums.
- One sub-module, ibex_rf_clear_ctrl, holds the FSM and counter. It outputs clr_we, clr_idx, busy and done.
- Storage, read muxes, write decode and the bypass logic stay in the top module.

Test Plan:
1. Reset, then read all 32 addresses on both ports -> all 0; wr_ready_o=1, clear_busy_o=0.
2. Write 0xDEADBEEF to x5 -> reading x5 the next cycle returns 0xDEADBEEF. Write 0x12345678 to x0 -> reading x0 returns 0.
3. NumWritePorts=2, both ports write x7 (port0=0x1, port1=0x2) -> wr_collision_o=1 that cycle and x7 reads 0x2. Ports writing x7 and x8 -> no collision, both stored.
4. Fill x1..x31 with their index, pulse clear_req_i -> clear_busy_o high 31 cycles, clear_done_o one pulse, all words 0. A write to x3 during CLEAR is dropped (x3=0 afterwards).
5. RV32E=1: write x20 (bit4 ignored) -> lands in x4. Clear lasts 15 cycles.
6. Assert rst_ni low at cycle 10 of a clear -> immediate IDLE, no done pulse, all words 0. With RF_WRITE_BYPASS_EN, writing 0xA5A5A5A5 to x9 while reading x9 -> same-cycle rdata 0xA5A5A5A5. Without the macro -> old value that cycle, 0xA5A5A5A5 the next.
